button_event_gen: RTL and testbench

Multi-channel push-button front end for the 7-segment clock. Samples raw switch inputs on the 8.192 kHz system clock, synchronises and debounces them, then emits a single-cycle event on each press plus auto-repeat events while a button is held. Its outputs drive the hour/minute increment and display-select inputs of the clock core. It replaces per-button level debouncing, so holding HR++ or MIN++ scrolls the value.

---
 rtl/button_event_pkg.sv | 19 +
 rtl/button_event_channel.sv | 124 ++++++++++++
 rtl/button_event_gen.sv | 36 +++
 tb/tb_button_event_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_event_pkg.sv
// Shared types and default timing for the push-button event front end.
// Timing defaults assume the 8.192 kHz clock-core system clock.
package button_event_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_e;

  localparam int DEBOUNCE_CYCLES_8K192 = 164;   // ~20 ms
  localparam int HOLD_DELAY_8K192      = 4096;  // 0.5 s
  localparam int REPEAT_PERIOD_8K192   = 1638;  // ~5 Hz

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_channel.sv
// One button channel: two-flop synchroniser, debounce counter and the
// IDLE/HOLD/REPEAT machine that turns a held level into press/repeat pulses.
module button_event_channel
  import button_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_8K192,
  parameter int HOLD_DELAY      = HOLD_DELAY_8K192,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_8K192,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_event,
  output logic o_press
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = max_int(HOLD_DELAY, REPEAT_PERIOD);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_DELAY - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_PERIOD - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  btn_state_e    r_state;
  btn_state_e    w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic          r_event;
  logic          w_event_nxt;
  logic          r_press;
  logic          w_press_nxt;

  // Synchroniser and debounce: level flips on the DEBOUNCE_CYCLES-th consecutive mismatch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      if (r_s2 != r_level) begin
        if (r_cnt == DB_LAST) begin
          r_level <= ~r_level;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_event <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_event <= w_event_nxt;
      r_press <= w_press_nxt;
    end
  end

  // A low level is tested before any timer expiry, so a release swallows a due repeat
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_event_nxt = 1'b0;
    w_press_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_level) begin
          w_press_nxt = 1'b1;
          w_event_nxt = 1'b1;
          w_timer_nxt = '0;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!r_level) begin
          w_state_nxt = IDLE;
        end else if (REPEAT_EN) begin
          if (r_timer == HOLD_LAST) begin
            w_event_nxt = 1'b1;
            w_timer_nxt = '0;
            w_state_nxt = REPEAT;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end
      end
      REPEAT: begin
        if (!r_level) begin
          w_state_nxt = IDLE;
        end else if (r_timer == REP_LAST) begin
          w_event_nxt = 1'b1;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_level = r_level;
  assign o_event = r_event;
  assign o_press = r_press;

endmodule

// File: rtl/button_event_gen.sv
// Multi-channel push-button front end: one independent debounce/repeat
// channel per button, feeding the clock core's increment and select inputs.
module button_event_gen
  import button_event_pkg::*;
#(
  parameter int               NUM_BTN         = 3,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_8K192,
  parameter int               HOLD_DELAY      = HOLD_DELAY_8K192,
  parameter int               REPEAT_PERIOD   = REPEAT_PERIOD_8K192,
  parameter logic [NUM_BTN-1:0] REPEAT_EN     = {NUM_BTN{1'b1}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_i,
  output logic [NUM_BTN-1:0] level_o,
  output logic [NUM_BTN-1:0] event_o,
  output logic [NUM_BTN-1:0] press_o
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    button_event_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_DELAY     (HOLD_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (REPEAT_EN[i])
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .i_btn  (btn_i[i]),
      .o_level(level_o[i]),
      .o_event(event_o[i]),
      .o_press(press_o[i])
    );
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Scoreboard bench for button_event_gen with short timing constants
// (debounce 4, hold 10, repeat 5, repeat disabled on channel 2).
module tb_button_event_gen;

  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 5;
  localparam int LAT = D + 3;  // cycles from driving btn to the press pulse

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] btn;
  logic [2:0] level_o;
  logic [2:0] event_o;
  logic [2:0] press_o;

  typedef struct {
    int cyc;
    int ch;
    bit press;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   nchk;
  int   nerr;

  button_event_gen #(
    .NUM_BTN        (3),
    .DEBOUNCE_CYCLES(D),
    .HOLD_DELAY     (H),
    .REPEAT_PERIOD  (R),
    .REPEAT_EN      (3'b011)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (btn),
    .level_o(level_o),
    .event_o(event_o),
    .press_o(press_o)
  );

  always #5 clk = ~clk;

  task automatic push(input int c, input int ch, input bit pr);
    exp_t e;
    e.cyc   = c;
    e.ch    = ch;
    e.press = pr;
    sb.push_back(e);
  endtask

  // Advance one edge and compare the pulse outputs against the scoreboard.
  task automatic tick();
    logic [2:0] exp_ev;
    logic [2:0] exp_pr;
    @(posedge clk);
    #1;
    cyc++;
    exp_ev = '0;
    exp_pr = '0;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_ev[sb[0].ch] = 1'b1;
      if (sb[0].press) exp_pr[sb[0].ch] = 1'b1;
      void'(sb.pop_front());
    end
    nchk++;
    if (event_o !== exp_ev) begin
      nerr++;
      $display("FAIL event_o cyc=%0d got=%b want=%b", cyc, event_o, exp_ev);
    end
    nchk++;
    if (press_o !== exp_pr) begin
      nerr++;
      $display("FAIL press_o cyc=%0d got=%b want=%b", cyc, press_o, exp_pr);
    end
  endtask

  task automatic check_drained(input string name);
    nchk++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL %s pending_pulses got=%0d want=0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic check_level(input string name, input int ch, input logic want);
    nchk++;
    if (level_o[ch] !== want) begin
      nerr++;
      $display("FAIL %s level_o[%0d] cyc=%0d got=%b want=%b", name, ch, cyc, level_o[ch], want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn   = '0;
    repeat (3) @(posedge clk);
    #1;
    nchk++;
    if (level_o !== 3'b000) begin
      nerr++;
      $display("FAIL reset_level got=%b want=000", level_o);
    end
    nchk++;
    if (event_o !== 3'b000) begin
      nerr++;
      $display("FAIL reset_event got=%b want=000", event_o);
    end
    nchk++;
    if (press_o !== 3'b000) begin
      nerr++;
      $display("FAIL reset_press got=%b want=000", press_o);
    end
    reset = 1'b0;
    cyc   = 0;
    repeat (4) tick();
  endtask

  task automatic test_single_press();
    int c0;
    c0 = cyc;
    btn[0] = 1'b1;
    push(c0 + LAT, 0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cyc == c0 + 8) btn[0] = 1'b0;
      if (cyc == c0 + 5)  check_level("single_pre", 0, 1'b0);
      if (cyc == c0 + 6)  check_level("single_rise", 0, 1'b1);
      if (cyc == c0 + 13) check_level("single_held", 0, 1'b1);
      if (cyc == c0 + 14) check_level("single_fall", 0, 1'b0);
    end
    check_drained("single_press");
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 20; i++) begin
      btn[1] = ((i % 4) < 2);
      tick();
      check_level("bounce", 1, 1'b0);
    end
    btn[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_level("bounce_tail", 1, 1'b0);
    end
    check_drained("bounce");
  endtask

  task automatic test_repeat();
    int c0;
    int p;
    c0 = cyc;
    p  = c0 + LAT;
    btn[0] = 1'b1;
    push(p, 0, 1'b1);
    for (int off = H; off <= 35; off += R) push(p + off, 0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cyc == p + 33) btn[0] = 1'b0;
      if (cyc == p + 38) check_level("repeat_held", 0, 1'b1);
      if (cyc == p + 39) check_level("repeat_fall", 0, 1'b0);
    end
    check_drained("repeat");
  endtask

  task automatic test_no_repeat();
    int c0;
    c0 = cyc;
    btn[2] = 1'b1;
    push(c0 + LAT, 2, 1'b1);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cyc == c0 + 40) btn[2] = 1'b0;
      if (cyc == c0 + 30) check_level("norep_held", 2, 1'b1);
    end
    check_drained("no_repeat");
  endtask

  task automatic test_simultaneous();
    int p;
    p = cyc + LAT;
    btn = 3'b111;
    for (int ch = 0; ch < 3; ch++) push(p, ch, 1'b1);
    for (int off = H; off <= 20; off += R) begin
      push(p + off, 0, 1'b0);
      push(p + off, 1, 1'b0);
    end
    for (int i = 0; i < 45; i++) begin
      tick();
      if (cyc == p + 18) btn = 3'b000;
    end
    check_drained("simultaneous");
  endtask

  task automatic test_reset_mid_hold();
    int p;
    p = cyc + LAT;
    btn[0] = 1'b1;
    push(p, 0, 1'b1);
    push(p + H, 0, 1'b0);
    push(p + 20, 0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cyc == p + 12) reset = 1'b1;
      if (cyc == p + 13) begin
        check_level("midreset", 0, 1'b0);
        reset = 1'b0;
      end
      if (cyc == p + 21) btn[0] = 1'b0;
    end
    check_drained("reset_mid_hold");
  endtask

  initial begin
    nchk  = 0;
    nerr  = 0;
    cyc   = 0;
    reset = 1'b1;
    btn   = '0;
    test_reset();
    test_single_press();
    test_bounce();
    test_repeat();
    test_no_repeat();
    test_simultaneous();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
